// File: rtl/clk_generator.sv
// Integer clock divider: clk_out = clk_base / (BASE_FREQ / OUT_FREQ), 50% duty at every ratio.
// First rising edge lands on the first clk_base posedge after reset release; reset forces the output low at once.
`timescale 1ns/1ps
module clk_generator #(
  parameter int BASE_FREQ = 30_000_000,
  parameter int OUT_FREQ  = 10_000_000
) (
  input  logic clk_base,
  input  logic rst_n,
  output logic clk_out
);

  localparam int DIV_RAW = (OUT_FREQ == 0) ? 0 : BASE_FREQ / OUT_FREQ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV <= 2) ? 1 : $clog2(DIV);

  generate
    if (OUT_FREQ == 0) begin : g_err_zero
      $fatal(1, "clk_generator: OUT_FREQ must be non-zero");
    end
    if (OUT_FREQ > BASE_FREQ) begin : g_err_fast
      $fatal(1, "clk_generator: OUT_FREQ (%0d) exceeds BASE_FREQ (%0d)", OUT_FREQ, BASE_FREQ);
    end
    if (DIV_RAW < 1) begin : g_err_div
      $fatal(1, "clk_generator: divide ratio below 1");
    end
  endgenerate

  generate
    if (DIV == 1) begin : g_bypass
      // Enable arms on a falling edge so the first gated pulse is a full high phase.
      logic r_en;

      always_ff @(negedge clk_base or negedge rst_n) begin
        if (!rst_n) r_en <= 1'b0;
        else        r_en <= 1'b1;
      end

      assign clk_out = clk_base & r_en;
    end else begin : g_div
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n)                      r_cnt <= '0;
        else if (r_cnt == CW'(DIV - 1))  r_cnt <= '0;
        else                             r_cnt <= r_cnt + CW'(1);
      end

      if (DIV % 2 == 0) begin : g_even
        logic r_hi;

        always_ff @(posedge clk_base or negedge rst_n) begin
          if (!rst_n) r_hi <= 1'b0;
          else        r_hi <= (r_cnt < CW'(DIV / 2));
        end

        assign clk_out = r_hi;
      end else begin : g_odd
        // r_hi covers (DIV-1)/2 periods; its half-cycle-late copy extends the OR by half a period.
        // The two OR inputs toggle on opposite clk_base edges, so the output cannot glitch.
        logic r_hi;
        logic r_hi_n;

        always_ff @(posedge clk_base or negedge rst_n) begin
          if (!rst_n) r_hi <= 1'b0;
          else        r_hi <= (r_cnt < CW'((DIV - 1) / 2));
        end

        always_ff @(negedge clk_base or negedge rst_n) begin
          if (!rst_n) r_hi_n <= 1'b0;
          else        r_hi_n <= r_hi;
        end

        assign clk_out = r_hi | r_hi_n;
      end
    end
  endgenerate

endmodule

// File: tb/tb_clk_generator.sv
// Bench for clk_generator: five ratios (3, 4, 5, bypass, truncated 30/7) on one base clock,
// checked against a half-period reference model, edge counts and measured period/high time.
`timescale 1ns/1ps
module tb_clk_generator;

  localparam int NDUT = 5;
  localparam int DIV_A = 30_000_000 / 10_000_000;
  localparam int DIV_B = 40_000_000 / 10_000_000;
  localparam int DIV_C = 50_000_000 / 10_000_000;
  localparam int DIV_D = 10_000_000 / 10_000_000;
  localparam int DIV_E = 30_000_000 / 7_000_000;

  logic       clk_base = 1'b0;
  logic       rst_n    = 1'b0;
  logic [4:0] w_out;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  h;
  bit  in_rst;
  real t_rel = 1.0e9;

  int  rise0 = 0, rise1 = 0, rise2 = 0, rise3 = 0, rise4 = 0;
  int  snap [NDUT];

  real t_rise  = -1.0;
  real per_min = 1.0e9, per_max = 0.0;
  real hi_min  = 1.0e9, hi_max  = 0.0;
  int  n_per = 0, n_hi = 0;

  always #16.67 clk_base = ~clk_base;

  clk_generator #(.BASE_FREQ(30_000_000), .OUT_FREQ(10_000_000)) u_div3 (
    .clk_base(clk_base), .rst_n(rst_n), .clk_out(w_out[0]));
  clk_generator #(.BASE_FREQ(40_000_000), .OUT_FREQ(10_000_000)) u_div4 (
    .clk_base(clk_base), .rst_n(rst_n), .clk_out(w_out[1]));
  clk_generator #(.BASE_FREQ(50_000_000), .OUT_FREQ(10_000_000)) u_div5 (
    .clk_base(clk_base), .rst_n(rst_n), .clk_out(w_out[2]));
  clk_generator #(.BASE_FREQ(10_000_000), .OUT_FREQ(10_000_000)) u_div1 (
    .clk_base(clk_base), .rst_n(rst_n), .clk_out(w_out[3]));
  clk_generator #(.BASE_FREQ(30_000_000), .OUT_FREQ(7_000_000)) u_trunc (
    .clk_base(clk_base), .rst_n(rst_n), .clk_out(w_out[4]));

  always @(posedge w_out[0]) rise0++;
  always @(posedge w_out[1]) rise1++;
  always @(posedge w_out[2]) rise2++;
  always @(posedge w_out[3]) rise3++;
  always @(posedge w_out[4]) rise4++;

  always @(posedge w_out[0]) begin
    real p;
    if (t_rise >= t_rel) begin
      p = $realtime - t_rise;
      if (p < per_min) per_min = p;
      if (p > per_max) per_max = p;
      n_per++;
    end
    t_rise = $realtime;
  end

  always @(negedge w_out[0]) begin
    real p;
    if (rst_n && t_rise >= t_rel) begin
      p = $realtime - t_rise;
      if (p < hi_min) hi_min = p;
      if (p > hi_max) hi_max = p;
      n_hi++;
    end
  end

  function automatic int div_of(input int i);
    case (i)
      0:       return DIV_A;
      1:       return DIV_B;
      2:       return DIV_C;
      3:       return DIV_D;
      default: return DIV_E;
    endcase
  endfunction

  function automatic int rise_of(input int i);
    case (i)
      0:       return rise0;
      1:       return rise1;
      2:       return rise2;
      3:       return rise3;
      default: return rise4;
    endcase
  endfunction

  // Reference: h counts base half-periods since P1; output is high for the first DIV halves of each 2*DIV.
  function automatic logic exp_out(input int div, input int hh);
    if (hh < 0) return 1'b0;
    return ((hh % (2 * div)) < div) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string tag, input int idx, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s dut%0d h=%0d t=%0t: observed %b expected %b", tag, idx, h, $realtime, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int idx, input int obs, input int exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0d expected %0d", tag, idx, obs, exp_v);
    end
  endtask

  task automatic check_range(input string tag, input real obs, input real lo, input real hi);
    n_assert++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %f expected within [%f, %f]", tag, obs, lo, hi);
    end
  endtask

  task automatic sample_all();
    for (int i = 0; i < NDUT; i++)
      check(in_rst ? "reset_level" : "run_level", i, w_out[i],
            in_rst ? 1'b0 : exp_out(div_of(i), h));
  endtask

  task automatic step();
    @(clk_base);
    #1;
    if (!in_rst) h++;
    sample_all();
  endtask

  task automatic release_reset();
    rst_n  = 1'b1;
    in_rst = 1'b0;
    t_rel  = $realtime;
    h      = -2;
    for (int i = 0; i < NDUT; i++) snap[i] = rise_of(i);
  endtask

  task automatic check_rises(input string tag);
    int n_pos;
    n_pos = h / 2 + 1;
    for (int i = 0; i < NDUT; i++)
      check_int(tag, i, rise_of(i) - snap[i], (n_pos + div_of(i) - 1) / div_of(i));
  endtask

  initial begin
    int nh;
    h      = -2;
    in_rst = 1'b1;

    #1;
    sample_all();
    @(posedge clk_base);
    #1;
    sample_all();
    #15.66;
    release_reset();

    nh = 6020 + 2 * $urandom_range(0, 60);
    repeat (nh) step();
    for (int k = 0; k < 12 && !(h >= 0 && h % 6 == 0); k++) step();
    check_rises("rises_phase1");

    #($urandom_range(2, 12));
    rst_n = 1'b0;
    t_rel = 1.0e9;
    #0.1;
    in_rst = 1'b1;
    for (int i = 0; i < NDUT; i++) check("reset_entry", i, w_out[i], 1'b0);

    repeat (4) step();
    #($urandom_range(1, 14));
    release_reset();

    repeat (600) step();
    check_rises("rises_phase2");

    check_range("period_count", real'(n_per), 1000.0, 1.0e6);
    check_range("period_min", per_min, 99.9, 100.1);
    check_range("period_max", per_max, 99.9, 100.1);
    check_range("high_count", real'(n_hi), 1000.0, 1.0e6);
    check_range("high_min", hi_min, 49.9, 50.1);
    check_range("high_max", hi_max, 49.9, 50.1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
